// File: rtl/cvxif_mac_copro.sv
// CV-X-IF multiply / multiply-accumulate coprocessor.
// Accepts custom-0 instructions (MUL, MAC, CLRACC, RDACC).
// A 32-step shift-add multiplier and an internal accumulator execute them.
// Results return on the result channel with full backpressure.
// Only one instruction is in flight at a time.
//
// Handshake rule on both channels: a transfer happens on the rising clock edge
// where valid && ready. The issue side only offers ready in IDLE, with both
// source operands valid. The result side holds valid, data, rd and id stable
// from the first RESULT cycle until the edge where x_result_ready_i is seen high.

package ibex_pkg;
  parameter int unsigned X_NUM_RS    = 2;
  parameter int unsigned X_ID_WIDTH  = 4;
  parameter int unsigned X_RFR_WIDTH = 32;
  parameter int unsigned X_RFW_WIDTH = 32;

  typedef struct packed {
    logic [31:0]                           instr;
    logic [1:0]                            mode;
    logic [X_ID_WIDTH-1:0]                 id;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0]  rs;
    logic [X_NUM_RS-1:0]                   rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic                   exc;
    logic [5:0]             exccode;
    logic                   err;
    logic                   dbg;
  } x_result_t;
endpackage

module cvxif_mac_copro #(
  parameter int unsigned XLEN   = 32,
  parameter logic [6:0]  Opcode = 7'b0001011
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   x_issue_valid_i,
  output logic                   x_issue_ready_o,
  input  ibex_pkg::x_issue_req_t x_issue_req_i,
  output ibex_pkg::x_issue_resp_t x_issue_resp_o,
  output logic                   x_result_valid_o,
  input  logic                   x_result_ready_i,
  output ibex_pkg::x_result_t    x_result_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    RESULT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_MUL = 2'd0,
    OP_MAC = 2'd1,
    OP_CLR = 2'd2,
    OP_RD  = 2'd3
  } op_e;

  state_e              state_q;
  op_e                 op_q;
  logic [XLEN-1:0]     acc_q;
  logic [XLEN-1:0]     mcand_q;
  logic [XLEN-1:0]     mplier_q;
  logic [XLEN-1:0]     product_q;
  logic [4:0]          count_q;
  logic [ibex_pkg::X_ID_WIDTH-1:0] id_q;
  logic [4:0]          rd_q;
  logic                result_valid_q;
  ibex_pkg::x_result_t result_q;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            accept;
  op_e             dec_op;
  logic [XLEN-1:0] product_next;
  logic [XLEN-1:0] mac_sum;
  logic            unused_ok;

  assign opcode = x_issue_req_i.instr[6:0];
  assign funct3 = x_issue_req_i.instr[14:12];
  assign funct7 = x_issue_req_i.instr[31:25];
  assign dec_op = op_e'(funct3[1:0]);

  // Only funct3 0..3 with funct7 == 0 under our major opcode are ours.
  assign accept = (opcode == Opcode) && (funct7 == 7'd0) && !funct3[2];

  // Operand fields and privilege mode are not needed by this unit.
  assign unused_ok = ^{x_issue_req_i.mode, x_issue_req_i.instr[24:15]};

  // Issue side is purely combinational: decode plus idle/operand gating.
  always_comb begin
    x_issue_resp_o           = '0;
    x_issue_resp_o.accept    = accept;
    x_issue_resp_o.writeback = accept;
    x_issue_ready_o          = (state_q == IDLE) && (x_issue_req_i.rs_valid == 2'b11);
  end

  // One shift-add step: add the multiplicand when the current multiplier LSB is set.
  assign product_next = product_q + (mplier_q[0] ? mcand_q : '0);
  assign mac_sum      = acc_q + product_next;

  assign x_result_valid_o = result_valid_q;
  assign x_result_o       = result_q;

  // Control FSM with the multiplier datapath, accumulator and registered result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      op_q           <= OP_MUL;
      acc_q          <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      product_q      <= '0;
      count_q        <= '0;
      id_q           <= '0;
      rd_q           <= '0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (x_issue_valid_i && x_issue_ready_o && accept) begin
            id_q      <= x_issue_req_i.id;
            rd_q      <= x_issue_req_i.instr[11:7];
            op_q      <= dec_op;
            mcand_q   <= x_issue_req_i.rs[0];
            mplier_q  <= x_issue_req_i.rs[1];
            product_q <= '0;
            count_q   <= '0;
            if (dec_op == OP_MUL || dec_op == OP_MAC) begin
              state_q <= BUSY;
            end else begin
              // CLRACC and RDACC both return the current accumulator value.
              result_q.id    <= x_issue_req_i.id;
              result_q.rd    <= x_issue_req_i.instr[11:7];
              result_q.data  <= acc_q;
              result_q.we    <= 1'b1;
              result_valid_q <= 1'b1;
              state_q        <= RESULT;
              if (dec_op == OP_CLR) begin
                acc_q <= '0;
              end
            end
          end
        end
        BUSY: begin
          product_q <= product_next;
          mcand_q   <= mcand_q << 1;
          mplier_q  <= mplier_q >> 1;
          count_q   <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            result_q.id    <= id_q;
            result_q.rd    <= rd_q;
            result_q.we    <= 1'b1;
            result_valid_q <= 1'b1;
            state_q        <= RESULT;
            if (op_q == OP_MAC) begin
              acc_q         <= mac_sum;
              result_q.data <= mac_sum;
            end else begin
              result_q.data <= product_next;
            end
          end
        end
        RESULT: begin
          if (x_result_ready_i) begin
            result_valid_q <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cvxif_mac_copro.sv
// Directed bench for cvxif_mac_copro: MUL/MAC/CLRACC/RDACC results, latency,
// rejects, result backpressure and reset in the middle of an operation.

module tb_cvxif_mac_copro;

  logic clk;
  logic rst_n;
  logic issue_valid;
  logic issue_ready;
  ibex_pkg::x_issue_req_t  issue_req;
  ibex_pkg::x_issue_resp_t issue_resp;
  logic result_valid;
  logic result_ready;
  ibex_pkg::x_result_t result;

  int errors;
  int checks;

  localparam logic [6:0] OPC = 7'b0001011;

  cvxif_mac_copro dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .x_issue_valid_i  (issue_valid),
    .x_issue_ready_o  (issue_ready),
    .x_issue_req_i    (issue_req),
    .x_issue_resp_o   (issue_resp),
    .x_result_valid_o (result_valid),
    .x_result_ready_i (result_ready),
    .x_result_o       (result)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, rd, opc};
  endfunction

  // Drives one issue request; returns just after the handshake edge.
  task automatic issue(input logic [31:0] instr, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] id,
                       input logic exp_acc);
    int n;
    n = 0;
    issue_req.instr    = instr;
    issue_req.rs[0]    = a;
    issue_req.rs[1]    = b;
    issue_req.id       = id;
    issue_req.rs_valid = 2'b11;
    issue_valid        = 1'b1;
    @(negedge clk);
    while (!issue_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (issue_ready !== 1'b1)
      $display("FAIL issue_ready instr=%h got=%b want=1", instr, issue_ready);
    if (issue_ready !== 1'b1) errors++;
    checks++;
    if (issue_resp.accept !== exp_acc || issue_resp.writeback !== exp_acc) begin
      errors++;
      $display("FAIL issue_resp instr=%h accept=%b writeback=%b want=%b",
               instr, issue_resp.accept, issue_resp.writeback, exp_acc);
    end
    @(posedge clk);
    #1 issue_valid = 1'b0;
  endtask

  // Waits for the result, checks it, completes the result handshake.
  task automatic collect(input logic [31:0] exp_data, input logic [4:0] exp_rd,
                         input logic [3:0] exp_id, input int exp_lat, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!result_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (result_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: result_valid never rose", name);
    end else begin
      checks++;
      if (n != exp_lat) begin
        errors++;
        $display("FAIL %s latency got=%0d want=%0d", name, n, exp_lat);
      end
      checks++;
      if (result.data !== exp_data) begin
        errors++;
        $display("FAIL %s data got=%h want=%h", name, result.data, exp_data);
      end
      checks++;
      if (result.rd !== exp_rd || result.id !== exp_id || result.we !== 1'b1) begin
        errors++;
        $display("FAIL %s fields rd=%0d id=%0d we=%b want rd=%0d id=%0d we=1",
                 name, result.rd, result.id, result.we, exp_rd, exp_id);
      end
      result_ready = 1'b1;
      @(posedge clk);
      #1 result_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0 || issue_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s after_handshake valid=%b issue_ready=%b want 0/1",
                 name, result_valid, issue_ready);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    issue_valid  = 1'b0;
    result_ready = 1'b0;
    issue_req    = '0;
    issue_req.rs_valid = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got=%b want=0", result_valid);
    end
    checks++;
    if (result !== '0) begin
      errors++;
      $display("FAIL reset_result got=%h want=0", result);
    end
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rs11 got=%b want=1", issue_ready);
    end
    issue_req.rs_valid = 2'b01;
    #1;
    checks++;
    if (issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_rs01 got=%b want=0", issue_ready);
    end
    issue_req.rs_valid = 2'b11;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mul();
    issue(mk(7'd0, 3'b000, 5'd5, OPC), 32'd7, 32'd6, 4'd3, 1'b1);
    collect(32'd42, 5'd5, 4'd3, 32, "mul_7x6");
  endtask

  task automatic test_overflow();
    issue(mk(7'd0, 3'b000, 5'd9, OPC), 32'hFFFF_FFFF, 32'd2, 4'd1, 1'b1);
    collect(32'hFFFF_FFFE, 5'd9, 4'd1, 32, "mul_wrap");
    issue(mk(7'd0, 3'b001, 5'd10, OPC), 32'h8000_0000, 32'd2, 4'd2, 1'b1);
    collect(32'h0000_0000, 5'd10, 4'd2, 32, "mac_wrap1");
    issue(mk(7'd0, 3'b001, 5'd11, OPC), 32'h8000_0000, 32'd2, 4'd4, 1'b1);
    collect(32'h0000_0000, 5'd11, 4'd4, 32, "mac_wrap2");
  endtask

  task automatic test_mac_seq();
    issue(mk(7'd0, 3'b001, 5'd1, OPC), 32'd3, 32'd4, 4'd5, 1'b1);
    collect(32'd12, 5'd1, 4'd5, 32, "mac_3x4");
    issue(mk(7'd0, 3'b001, 5'd2, OPC), 32'd5, 32'd5, 4'd6, 1'b1);
    collect(32'd37, 5'd2, 4'd6, 32, "mac_5x5");
    issue(mk(7'd0, 3'b011, 5'd3, OPC), 32'd0, 32'd0, 4'd7, 1'b1);
    collect(32'd37, 5'd3, 4'd7, 0, "rdacc_37");
    issue(mk(7'd0, 3'b010, 5'd4, OPC), 32'd0, 32'd0, 4'd8, 1'b1);
    collect(32'd37, 5'd4, 4'd8, 0, "clracc");
    issue(mk(7'd0, 3'b011, 5'd31, OPC), 32'd0, 32'd0, 4'd15, 1'b1);
    collect(32'd0, 5'd31, 4'd15, 0, "rdacc_0");
  endtask

  task automatic test_reject();
    logic [31:0] rej [2];
    int bad;
    rej[0] = mk(7'd0, 3'b111, 5'd6, OPC);
    rej[1] = mk(7'd0, 3'b000, 5'd6, 7'b0110011);
    for (int i = 0; i < 2; i++) begin
      issue(rej[i], 32'd7, 32'd6, 4'd9, 1'b0);
      bad = 0;
      repeat (40) begin
        @(negedge clk);
        if (result_valid !== 1'b0 || issue_ready !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL reject_%0d bad_cycles got=%0d want=0", i, bad);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    issue(mk(7'd0, 3'b000, 5'd12, OPC), 32'd9, 32'd9, 4'd10, 1'b1);
    n = 0;
    @(negedge clk);
    while (!result_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    bad = 0;
    repeat (10) begin
      if (result_valid !== 1'b1 || result.data !== 32'd81 || result.rd !== 5'd12 ||
          result.id !== 4'd10 || issue_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold bad_cycles got=%0d want=0 (data=%h)", bad, result.data);
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1 result_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release valid=%b issue_ready=%b want 0/1",
               result_valid, issue_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int bad;
    issue(mk(7'd0, 3'b001, 5'd13, OPC), 32'd2, 32'd3, 4'd11, 1'b1);
    collect(32'd6, 5'd13, 4'd11, 32, "mac_2x3");
    issue(mk(7'd0, 3'b000, 5'd14, OPC), 32'd100, 32'd100, 4'd12, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready got=%b want=0", issue_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (result_valid !== 1'b0 || result !== '0 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset valid=%b result=%h issue_ready=%b want 0/0/1",
               result_valid, result, issue_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (result_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midreset_no_result bad_cycles got=%0d want=0", bad);
    end
    @(posedge clk);
    #1;
    issue(mk(7'd0, 3'b011, 5'd15, OPC), 32'd0, 32'd0, 4'd13, 1'b1);
    collect(32'd0, 5'd15, 4'd13, 0, "rdacc_after_reset");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_mul();
    test_overflow();
    test_mac_seq();
    test_reject();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cvxif_mac_copro.md
# cvxif_mac_copro

CV-X-IF coprocessor that sits on the ibex X-interface issue and result channels, beside the FPU coprocessor in the simple system. It accepts custom-0 instructions for 32-bit multiply and multiply-accumulate, and executes them with an iterative shift-add multiplier and an internal accumulator. It returns the result to the core's register file through the result channel, with full backpressure support. Only one instruction is in flight at a time.

## Interface
Parameters:
- `XLEN`, default 32: operand, accumulator and result width.
- `Opcode`, default 7'b0001011: major opcode accepted (custom-0).

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `x_issue_valid_i`, in, 1: issue request valid.
- `x_issue_ready_o`, out, 1: issue request ready.
- `x_issue_req_i`, in, `ibex_pkg::x_issue_req_t`: issue request. Uses the `.instr`, `.rs[0]`, `.rs[1]`, `.rs_valid` and `.id` fields.
- `x_issue_resp_o`, out, `ibex_pkg::x_issue_resp_t`: issue response. Drives `.accept` and `.writeback`; all other fields are 0.
- `x_result_valid_o`, out, 1: result valid.
- `x_result_ready_i`, in, 1: result ready.
- `x_result_o`, out, `ibex_pkg::x_result_t`: result. Drives `.id`, `.data`, `.rd` and `.we`; all other fields are 0.

## Operation
Decode is combinational on `x_issue_req_i.instr`. An instruction is accepted only when opcode == `Opcode` and funct7 == 0. The accepted funct3 values are:
- 000 MUL: rd = (rs1*rs2)[31:0].
- 001 MAC: acc = acc + (rs1*rs2)[31:0]; rd = new acc.
- 010 CLRACC: rd = old acc; acc = 0.
- 011 RDACC: rd = acc.
- Any other funct3, or a wrong opcode or funct7: `accept`=0, `writeback`=0.

Issue response:
- `accept` and `writeback` are both 1 for accepted instructions.
- The response is meaningful only while `x_issue_valid_i` is high.

Issue handshake:
- The handshake completes on `x_issue_valid_i && x_issue_ready_o`.
- `x_issue_ready_o` = (state==IDLE) && `rs_valid[1:0]`==2'b11.
- A rejected instruction still completes the handshake and leaves the state unchanged.

On an accepted handshake, the block latches `id`, `rd` (= instr[11:7]), the op, rs1 (multiplicand) and rs2 (multiplier).

State machine:
- IDLE:
  - MUL or MAC: go to BUSY, with count=0 and product=0.
  - CLRACC or RDACC: go to RESULT, with the result data latched.
- BUSY: each cycle, if multiplier[0] then product += multiplicand. Then multiplicand <<= 1 and multiplier >>= 1, all modulo 2^32. count increments. When count==31 the step completes and the FSM goes to RESULT:
  - MUL: data = final product.
  - MAC: acc updated, data = new acc.
- RESULT: `x_result_valid_o`=1 with stable outputs. On `x_result_ready_i`, go to IDLE.

Arithmetic:
- All arithmetic is unsigned and truncated to XLEN.
- Accumulator overflow wraps silently.
- Signedness has no effect on the low 32 bits.

Result fields: `we`=1, `rd` = latched rd, `id` = latched id.

## Timing
Reset values:
- state=IDLE.
- `x_result_valid_o`=0.
- `x_result_o` all 0.
- acc=0.
- `x_issue_ready_o` follows `rs_valid`; it is 1 when `rs_valid`==2'b11.
- `x_issue_resp_o` depends only on the instruction decode.

Latency, with T = issue handshake cycle:
- MUL/MAC: BUSY during T+1..T+32; `x_result_valid_o` high from T+33.
- CLRACC/RDACC: `x_result_valid_o` high from T+1.

Result handshake:
- Completes in cycle R, when valid && ready.
- State is IDLE and `x_issue_ready_o` can be high from R+1. There is no issue/result overlap.

Backpressure:
- Valid, data, rd and id stay stable until ready.
- Ready held high in the first RESULT cycle gives a single-cycle valid pulse.

Reset asserted mid-operation:
- Immediately returns to IDLE and clears acc and all outputs.
- No result is produced for the aborted instruction.

`x_issue_valid_i` high during BUSY/RESULT is ignored, because ready is 0.

## Test plan
- MUL: rs1=7, rs2=6 -> accept=1; valid at T+33 with data=42, rd=instr[11:7], id echoed, we=1.
- Overflow: MUL 0xFFFFFFFF*2 -> data=0xFFFFFFFE. Then MAC 0x80000000*2 twice from acc=0 -> data 0x00000000 both times (wraps).
- MAC/RDACC/CLRACC sequence: MAC 3*4, then MAC 5*5 -> 12, then 37. RDACC -> 37 at T+1. CLRACC -> 37. RDACC -> 0.
- Reject cases: funct3=111, or opcode 0110011 -> handshake completes, accept=0, writeback=0. No result_valid for 40 cycles. Ready stays 1.
- Backpressure: hold `x_result_ready_i`=0 for 10 cycles after MUL 9*9 -> valid held with data=81 stable and issue_ready=0. After the ready pulse, issue_ready=1 on the next cycle.
- Reset at T+10 of MUL 100*100 -> valid=0, acc=0, IDLE. A following RDACC returns 0.
